// File: rtl/alink_wb_if.sv
// Wishbone B4 signal bundle between the SoC interconnect and the ALINK register block.
interface alink_wb_if;
  logic        ALINK_CYC_I;
  logic        ALINK_STB_I;
  logic        ALINK_WE_I;
  logic        ALINK_LOCK_I;
  logic [2:0]  ALINK_CTI_I;
  logic [1:0]  ALINK_BTE_I;
  logic [5:0]  ALINK_ADR_I;
  logic [31:0] ALINK_DAT_I;
  logic [3:0]  ALINK_SEL_I;
  logic        ALINK_ACK_O;
  logic        ALINK_ERR_O;
  logic        ALINK_RTY_O;
  logic [31:0] ALINK_DAT_O;

  modport master (
    output ALINK_CYC_I, ALINK_STB_I, ALINK_WE_I, ALINK_LOCK_I, ALINK_CTI_I,
    output ALINK_BTE_I, ALINK_ADR_I, ALINK_DAT_I, ALINK_SEL_I,
    input  ALINK_ACK_O, ALINK_ERR_O, ALINK_RTY_O, ALINK_DAT_O
  );

  modport slave (
    input  ALINK_CYC_I, ALINK_STB_I, ALINK_WE_I, ALINK_LOCK_I, ALINK_CTI_I,
    input  ALINK_BTE_I, ALINK_ADR_I, ALINK_DAT_I, ALINK_SEL_I,
    output ALINK_ACK_O, ALINK_ERR_O, ALINK_RTY_O, ALINK_DAT_O
  );
endinterface

// File: rtl/alink_wb_slave.sv
// ALINK Wishbone register block: TX FIFO push, RX FIFO pop, PHY mask, status/busy view, flush.
// Optional scratch register at 0x14 is enabled by defining ALINK_SCRATCH_EN.
module alink_wb_slave #(
  parameter int PHY_NUM = 32,
  parameter int TXCNT_W = 11,
  parameter int RXCNT_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  alink_wb_if.slave          wb,
  output logic               txfifo_push,
  output logic [31:0]        txfifo_din,
  input  logic [RXCNT_W-1:0] rxcnt,
  input  logic               rxempty,
  input  logic [TXCNT_W-1:0] txcnt,
  output logic               reg_flush,
  input  logic               txfull,
  output logic [PHY_NUM-1:0] reg_mask,
  input  logic [PHY_NUM-1:0] busy,
  output logic               rxfifo_pop,
  input  logic [31:0]        rxfifo_dout
);

  localparam logic [3:0] A_TXDATA  = 4'h0;
  localparam logic [3:0] A_STATUS  = 4'h1;
  localparam logic [3:0] A_MASK    = 4'h2;
  localparam logic [3:0] A_BUSY    = 4'h3;
  localparam logic [3:0] A_RXDATA  = 4'h4;
  localparam logic [3:0] A_SCRATCH = 4'h5;

  // Handshake: an access is accepted when STB is high and ACK is low; ACK is
  // registered from that, so each access gets exactly one ACK cycle one clock
  // after STB, and a held STB is acknowledged on alternate cycles.
  logic        ack_q;
  logic [31:0] dat_q;
  logic        overflow;
  logic        accept;
  logic [3:0]  reg_sel;
  logic        rx_avail;
  logic [31:0] status_word;
  logic [31:0] mask_ext;
  logic [31:0] mask_new;
  logic [31:0] rdata;
  logic [31:0] scratch;
  logic        unused_ok;

  assign accept   = wb.ALINK_STB_I & ~ack_q;
  assign reg_sel  = wb.ALINK_ADR_I[5:2];
  assign rx_avail = |rxcnt;

  assign wb.ALINK_ACK_O = ack_q;
  assign wb.ALINK_DAT_O = dat_q;
  assign wb.ALINK_ERR_O = 1'b0;
  assign wb.ALINK_RTY_O = 1'b0;

  assign unused_ok = &{1'b0, wb.ALINK_CYC_I, wb.ALINK_LOCK_I, wb.ALINK_CTI_I,
                       wb.ALINK_BTE_I, wb.ALINK_ADR_I[1:0]};

  assign status_word = {8'h00, overflow, txfull, rxempty, 11'(txcnt), 10'(rxcnt)};
  assign mask_ext    = 32'(reg_mask);

  always_comb begin
    mask_new = mask_ext;
    for (int b = 0; b < 4; b++) begin
      if (wb.ALINK_SEL_I[b]) mask_new[8*b +: 8] = wb.ALINK_DAT_I[8*b +: 8];
    end
  end

`ifdef ALINK_SCRATCH_EN
  logic [31:0] scratch_new;

  always_comb begin
    scratch_new = scratch;
    for (int b = 0; b < 4; b++) begin
      if (wb.ALINK_SEL_I[b]) scratch_new[8*b +: 8] = wb.ALINK_DAT_I[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch <= 32'h0;
    end else if (accept && wb.ALINK_WE_I && reg_sel == A_SCRATCH) begin
      scratch <= scratch_new;
    end
  end
`else
  assign scratch = 32'h0;
`endif

  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      A_STATUS:  rdata = status_word;
      A_MASK:    rdata = mask_ext;
      A_BUSY:    rdata = 32'(busy);
      A_RXDATA:  rdata = rx_avail ? rxfifo_dout : 32'h0;
`ifdef ALINK_SCRATCH_EN
      A_SCRATCH: rdata = scratch;
`endif
      default:   rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      txfifo_push <= 1'b0;
      txfifo_din  <= 32'h0;
      reg_flush   <= 1'b0;
      reg_mask    <= '0;
      rxfifo_pop  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      ack_q       <= accept;
      txfifo_push <= 1'b0;
      rxfifo_pop  <= 1'b0;
      reg_flush   <= 1'b0;
      if (accept) begin
        if (wb.ALINK_WE_I) begin
          case (reg_sel)
            A_TXDATA: begin
              // A full FIFO drops the word and latches the sticky overflow flag.
              if (txfull) begin
                overflow <= 1'b1;
              end else begin
                txfifo_din  <= wb.ALINK_DAT_I;
                txfifo_push <= 1'b1;
              end
            end
            A_STATUS: reg_flush <= wb.ALINK_DAT_I[0];
            A_MASK:   reg_mask  <= PHY_NUM'(mask_new);
            default:  ;
          endcase
        end else begin
          dat_q <= rdata;
          if (reg_sel == A_RXDATA && rx_avail) rxfifo_pop <= 1'b1;
          if (reg_sel == A_STATUS) overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alink_wb_slave.sv
// Directed plus randomized bench for alink_wb_slave with a register-map reference model.
module tb_alink_wb_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        txfifo_push;
  logic [31:0] txfifo_din;
  logic [9:0]  rxcnt = '0;
  logic        rxempty = 1'b1;
  logic [10:0] txcnt = '0;
  logic        reg_flush;
  logic        txfull = 1'b0;
  logic [31:0] reg_mask;
  logic [31:0] busy = '0;
  logic        rxfifo_pop;
  logic [31:0] rxfifo_dout = '0;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_mask = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_scratch = '0;
  logic [31:0] m_dat_o = '0;

  alink_wb_if wb();

  alink_wb_slave #(.PHY_NUM(32), .TXCNT_W(11), .RXCNT_W(10)) dut (
    .clk(clk), .rst(rst), .wb(wb),
    .txfifo_push(txfifo_push), .txfifo_din(txfifo_din),
    .rxcnt(rxcnt), .rxempty(rxempty), .txcnt(txcnt),
    .reg_flush(reg_flush), .txfull(txfull), .reg_mask(reg_mask),
    .busy(busy), .rxfifo_pop(rxfifo_pop), .rxfifo_dout(rxfifo_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One complete access: STB for one cycle, then idle. Model is applied on the ACK edge.
  task automatic access(input bit we, input logic [5:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    int r;
    logic exp_push, exp_pop, exp_flush;
    logic [31:0] exp_rd;
    r = int'(adr[5:2]);
    exp_push  = we && r == 0 && !txfull;
    exp_pop   = !we && r == 4 && rxcnt != 0;
    exp_flush = we && r == 1 && dat[0];
    case (r)
      1: exp_rd = {8'h00, m_ovf, txfull, rxempty, txcnt, rxcnt};
      2: exp_rd = m_mask;
      3: exp_rd = busy;
      4: exp_rd = (rxcnt != 0) ? rxfifo_dout : 32'h0;
`ifdef ALINK_SCRATCH_EN
      5: exp_rd = m_scratch;
`endif
      default: exp_rd = 32'h0;
    endcase

    @(negedge clk);
    wb.ALINK_STB_I = 1'b1;
    wb.ALINK_CYC_I = 1'b1;
    wb.ALINK_WE_I  = we;
    wb.ALINK_ADR_I = adr;
    wb.ALINK_DAT_I = dat;
    wb.ALINK_SEL_I = sel;
    #1 chk("ack_before_edge", 32'(wb.ALINK_ACK_O), 32'd0);

    // model update on the ACK edge
    if (we) begin
      if (r == 0 && txfull) m_ovf = 1'b1;
      if (r == 2) m_mask = bytes_merge(m_mask, dat, sel);
`ifdef ALINK_SCRATCH_EN
      if (r == 5) m_scratch = bytes_merge(m_scratch, dat, sel);
`endif
    end else begin
      m_dat_o = exp_rd;
      if (r == 1) m_ovf = 1'b0;
    end

    @(posedge clk); #1;
    chk("ack", 32'(wb.ALINK_ACK_O), 32'd1);
    chk("push", 32'(txfifo_push), 32'(exp_push));
    chk("pop", 32'(rxfifo_pop), 32'(exp_pop));
    chk("flush", 32'(reg_flush), 32'(exp_flush));
    if (exp_push) chk("txfifo_din", txfifo_din, dat);
    chk("dat_o", wb.ALINK_DAT_O, m_dat_o);
    chk("reg_mask", reg_mask, m_mask);
    chk("err_rty", {30'd0, wb.ALINK_ERR_O, wb.ALINK_RTY_O}, 32'd0);

    @(negedge clk);
    wb.ALINK_STB_I = 1'b0;
    wb.ALINK_CYC_I = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", 32'(wb.ALINK_ACK_O), 32'd0);
    chk("strobes_drop", {29'd0, txfifo_push, rxfifo_pop, reg_flush}, 32'd0);
    chk("dat_o_hold", wb.ALINK_DAT_O, m_dat_o);
  endtask

  initial begin
    wb.ALINK_CYC_I = 1'b0; wb.ALINK_STB_I = 1'b0; wb.ALINK_WE_I = 1'b0;
    wb.ALINK_LOCK_I = 1'b0; wb.ALINK_CTI_I = 3'b0; wb.ALINK_BTE_I = 2'b0;
    wb.ALINK_ADR_I = 6'h0; wb.ALINK_DAT_I = 32'h0; wb.ALINK_SEL_I = 4'h0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wb.ALINK_ACK_O), 32'd0);
    chk("rst_dat_o", wb.ALINK_DAT_O, 32'd0);
    chk("rst_strobes", {29'd0, txfifo_push, rxfifo_pop, reg_flush}, 32'd0);
    chk("rst_din", txfifo_din, 32'd0);
    chk("rst_mask", reg_mask, 32'd0);
    @(negedge clk) rst = 1'b1;

    // reset state through the bus
    access(0, 6'h08, 32'h0, 4'h0);
    chk("mask_reset_read", wb.ALINK_DAT_O, 32'h0);
    access(0, 6'h04, 32'h0, 4'h0);
    chk("status_reset_read", wb.ALINK_DAT_O, 32'h0020_0000);

    // TX push and overflow
    access(1, 6'h00, 32'h1234_5678, 4'hF);
    txfull = 1'b1;
    access(1, 6'h00, 32'h1234_5678, 4'hF);
    txfull = 1'b0;
    access(0, 6'h04, 32'h0, 4'h0);
    chk("status_ovf_set", 32'(wb.ALINK_DAT_O[23]), 32'd1);
    access(0, 6'h04, 32'h0, 4'h0);
    chk("status_ovf_clr", 32'(wb.ALINK_DAT_O[23]), 32'd0);

    // partial mask write
    access(1, 6'h08, 32'hFFFF_FFFF, 4'b0011);
    access(0, 6'h08, 32'h0, 4'h0);
    chk("mask_partial", wb.ALINK_DAT_O, 32'h0000_FFFF);

    // RX pop and empty read
    rxcnt = 10'd5; rxempty = 1'b0; rxfifo_dout = 32'hDEAD_BEEF;
    access(0, 6'h10, 32'h0, 4'h0);
    chk("rx_data", wb.ALINK_DAT_O, 32'hDEAD_BEEF);
    rxcnt = 10'd0; rxempty = 1'b1;
    access(0, 6'h10, 32'h0, 4'h0);
    chk("rx_empty_data", wb.ALINK_DAT_O, 32'h0);

    // flush keeps mask and overflow; busy view
    txfull = 1'b1;
    access(1, 6'h00, 32'hAAAA_5555, 4'hF);
    txfull = 1'b0;
    access(1, 6'h04, 32'h1, 4'hF);
    access(0, 6'h04, 32'h0, 4'h0);
    chk("ovf_survives_flush", 32'(wb.ALINK_DAT_O[23]), 32'd1);
    busy = 32'hA5A5_0001;
    access(0, 6'h0C, 32'h0, 4'h0);
    chk("busy_read", wb.ALINK_DAT_O, 32'hA5A5_0001);

    // scratch / unmapped 0x14
    access(1, 6'h14, 32'hCAFE_F00D, 4'hF);
    access(0, 6'h14, 32'h0, 4'h0);
`ifdef ALINK_SCRATCH_EN
    chk("scratch_read", wb.ALINK_DAT_O, 32'hCAFE_F00D);
`else
    chk("scratch_read", wb.ALINK_DAT_O, 32'h0);
`endif

    // held STB: ACK on alternate cycles
    @(negedge clk);
    wb.ALINK_STB_I = 1'b1; wb.ALINK_WE_I = 1'b0; wb.ALINK_ADR_I = 6'h0C;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("held_stb_ack", 32'(wb.ALINK_ACK_O), (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk) wb.ALINK_STB_I = 1'b0;
    @(posedge clk); #1;
    chk("held_stb_ack_end", 32'(wb.ALINK_ACK_O), 32'd0);
    m_dat_o = busy;

    // reset mid-access drops the access
    @(negedge clk);
    wb.ALINK_STB_I = 1'b1; wb.ALINK_WE_I = 1'b1; wb.ALINK_ADR_I = 6'h00;
    wb.ALINK_DAT_I = 32'h5555_AAAA;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ack", 32'(wb.ALINK_ACK_O), 32'd0);
    chk("rst_mid_push", 32'(txfifo_push), 32'd0);
    chk("rst_mid_mask", reg_mask, 32'd0);
    @(negedge clk);
    wb.ALINK_STB_I = 1'b0;
    rst = 1'b1;
    m_mask = '0; m_ovf = 1'b0; m_scratch = '0; m_dat_o = '0;

    // randomized accesses against the model
    for (int i = 0; i < 80; i++) begin
      logic [5:0] adr;
      int pick;
      pick = $urandom_range(0, 7);
      adr = (pick == 6) ? 6'h18 : (pick == 7) ? 6'h3C : 6'(pick * 4);
      adr[1:0] = 2'($urandom_range(0, 3));
      txfull      = ($urandom_range(0, 3) == 0);
      rxcnt       = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      rxempty     = $urandom_range(0, 1) == 1;
      txcnt       = 11'($urandom_range(0, 2047));
      busy        = $urandom;
      rxfifo_dout = $urandom;
      access($urandom_range(0, 1) == 1, adr, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alink_wb_slave.md
Name: alink_wb_slave

Overview:
- Wishbone slave register block of the ALINK ASIC-link controller.
- Bridges the CPU bus to the TX task FIFO (push), RX report FIFO (pop), the per-PHY mask register, the busy/status view and the FIFO flush strobe.
- Sits between the SoC Wishbone interconnect and the alink TX/RX FIFOs, the TX arbiter and the RX controller.

Parameters:
- PHY_NUM, 32, number of PHY lanes; width of reg_mask and busy.
- TXCNT_W, 11, width of the TX FIFO occupancy input.
- RXCNT_W, 10, width of the RX FIFO occupancy input.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ALINK_CYC_I  in  1  Wishbone cycle; unused.
- ALINK_STB_I  in  1  strobe; qualifies every access.
- ALINK_WE_I  in  1  1 = write, 0 = read.
- ALINK_LOCK_I  in  1  unused.
- ALINK_CTI_I  in  3  unused.
- ALINK_BTE_I  in  2  unused.
- ALINK_ADR_I  in  6  byte address; ADR[5:2] selects the register.
- ALINK_DAT_I  in  32  write data.
- ALINK_SEL_I  in  4  byte enables; honoured for MASK and SCRATCH only.
- ALINK_ACK_O  out  1  registered acknowledge.
- ALINK_ERR_O  out  1  constant 0.
- ALINK_RTY_O  out  1  constant 0.
- ALINK_DAT_O  out  32  registered read data.
- txfifo_push  out  1  one-cycle TX FIFO write strobe.
- txfifo_din  out  32  TX FIFO write data.
- rxcnt  in  RXCNT_W  RX FIFO occupancy.
- rxempty  in  1  RX FIFO holds fewer than one complete report.
- txcnt  in  TXCNT_W  TX FIFO occupancy.
- reg_flush  out  1  one-cycle flush pulse to both FIFOs and the controllers.
- txfull  in  1  TX FIFO cannot accept another full task.
- reg_mask  out  PHY_NUM  PHY enable mask.
- busy  in  PHY_NUM  per-PHY busy flags.
- rxfifo_pop  out  1  one-cycle RX FIFO read strobe.
- rxfifo_dout  in  32  RX FIFO head word; first-word-fall-through.

Behaviour:
- Reset values (while rst=0): ACK_O=0, DAT_O=0, txfifo_push=0, txfifo_din=0, reg_flush=0, reg_mask=0, rxfifo_pop=0, overflow flag=0, scratch=0.
- Handshake: ACK_O <= STB_I & ~ACK_O.
  - Exactly one ACK cycle per access, one clock after STB.
  - Back-to-back held STB gives ACK on alternate cycles.
  - Every side effect (push/pop/flush/register write) occurs on the same clock edge that raises ACK, i.e. once per access.
- Register map (ADR[5:2]):
  - 0x00 TXDATA W: txfifo_din<=DAT_I and txfifo_push=1 for one cycle. If txfull=1 the push is suppressed and the sticky overflow flag is set. Reads return 0.
  - 0x04 STATUS R: [9:0] rxcnt (zero-extended), [20:10] txcnt, [21] rxempty, [22] txfull, [23] overflow, [31:24] 0. Reading clears overflow on the ACK edge; a simultaneous suppressed push wins and sets it.
  - 0x04 STATUS W: DAT_I[0]=1 produces a one-cycle reg_flush pulse; other bits are ignored.
  - 0x08 MASK RW: per-byte write under SEL_I; reads return reg_mask.
  - 0x0C BUSY R: returns busy. Writes are ignored.
  - 0x10 RXDATA R: DAT_O<=rxfifo_dout. If rxcnt!=0, rxfifo_pop=1 for one cycle concurrent with ACK. If rxcnt==0 there is no pop and DAT_O<=0. Writes are ignored.
  - All other addresses: read 0, writes ignored, still ACKed.
- DAT_O is updated only on read-ACK edges and holds its value otherwise.
- Strobes (push/pop/flush) are never asserted for more than one cycle.
- Strobes are never asserted together, since there is only one access per ACK.
- reg_flush does not reset reg_mask or the overflow flag.
- Asserting rst mid-access drops the access: no ACK and no side effect.

Optional Feature:
- Macro ALINK_SCRATCH_EN.
- Defined: address 0x14 is a 32-bit RW scratch register with byte enables, reset 0.
- Undefined: 0x14 behaves as an unmapped address (read 0, write ignored, ACKed).

Test Plan:
- Reset then read MASK, STATUS with rxcnt=0, txcnt=0, rxempty=1, txfull=0 -> MASK reads 0x0, STATUS reads 0x0020_0000, ACK one cycle after STB.
- Write 0x1234_5678 to 0x00 with txfull=0 -> txfifo_din=0x12345678, txfifo_push high exactly one cycle.
- Repeat the write with txfull=1 -> no push, STATUS[23]=1 on next read, then 0 on the following read.
- Write MASK 0xFFFF_FFFF with SEL=4'b0011 after reset -> MASK reads 0x0000_FFFF.
- rxcnt=5, rxfifo_dout=0xDEAD_BEEF, read 0x10 -> DAT_O=0xDEADBEEF, rxfifo_pop one cycle.
- rxcnt=0, read 0x10 -> DAT_O=0, no pop.
- Write 0x1 to 0x04 -> reg_flush one-cycle pulse. Read 0x0C with busy=0xA5A5_0001 -> 0xA5A50001.
- With ALINK_SCRATCH_EN: write/read 0x14 -> 0xCAFEF00D. Without it: 0x14 reads 0.
